// File: rtl/cpu_ifetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: default reset PC,
// FSM state encodings, FIFO entry layout and an address alignment helper.
package cpu_ifetch_queue_pkg;

    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_1000;

    typedef enum logic [1:0] {
        IFQ_IDLE    = 2'd0,
        IFQ_REQ     = 2'd1,
        IFQ_DISCARD = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ifq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cpu_ifq_fifo.sv
// Generic synchronous FIFO of 64-bit entries; clear outranks push and pop.
module cpu_ifq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [63:0]              din,
    output logic [63:0]              dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][63:0] mem;
    logic [AW-1:0]          rptr;
    logic [AW-1:0]          wptr;
    logic                   do_push;
    logic                   do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_ifetch_queue.sv
// Instruction prefetch queue: sequential classic-Wishbone reads buffered in a
// FIFO of {addr, data}, popped by the fetch stage, redirected by flush.
module cpu_ifetch_queue
    import cpu_ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] word_o,
    output logic [31:0] word_addr_o
);
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    ifq_state_e    state;
    logic [31:0]   fa;
    logic [31:0]   fa_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          room;
    ifq_entry_t    ent_in;
    ifq_entry_t    ent_out;

    assign push    = (state == IFQ_REQ) && wb_ack_i && !flush_i && !full;
    assign pop     = valid_o && ready_i;
    assign count_n = flush_i ? '0 : count + CW'(push) - CW'(pop);
    // A request is only issued when a slot is guaranteed for its data.
    assign room    = (count_n < CW'(DEPTH));

    assign ent_in      = '{addr: fa, data: wb_dat_i};
    assign valid_o     = !empty;
    assign word_o      = ent_out.data;
    assign word_addr_o = ent_out.addr;
    assign wb_cyc_o    = wb_stb_o;

    always_comb begin
        fa_n = fa;
        if (flush_i)
            fa_n = word_align(flush_addr_i);
        else if (push)
            fa_n = fa + 32'd4;
    end

    cpu_ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .din   (ent_in),
        .dout  (ent_out),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // DISCARD keeps stb and adr steady until the stale ack arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IFQ_IDLE;
            fa       <= START_PC;
            wb_adr_o <= START_PC;
            wb_stb_o <= 1'b0;
        end else begin
            fa <= fa_n;
            case (state)
                IFQ_IDLE: begin
                    if (room) begin
                        state    <= IFQ_REQ;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= fa_n;
                    end
                end
                IFQ_REQ: begin
                    if (wb_ack_i) begin
                        if (room) begin
                            wb_adr_o <= fa_n;
                        end else begin
                            state    <= IFQ_IDLE;
                            wb_stb_o <= 1'b0;
                        end
                    end else if (flush_i) begin
                        state <= IFQ_DISCARD;
                    end
                end
                IFQ_DISCARD: begin
                    if (wb_ack_i) begin
                        state    <= IFQ_REQ;
                        wb_adr_o <= fa_n;
                    end
                end
                default: begin
                    state    <= IFQ_IDLE;
                    wb_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ifetch_queue.sv
// Bench for cpu_ifetch_queue: directed scenarios plus a randomized run checked
// against a transaction-level queue model.
module tb_cpu_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wb_ack, flush, ready;
    logic [31:0] wb_dat, flush_addr;
    logic [31:0] wb_adr, word, word_addr;
    logic        wb_cyc, wb_stb, valid;

    logic        rst_w, ack_w, flush_w, ready_w;
    logic [31:0] dat_w, flush_addr_w;
    logic [31:0] adr_w, word_w, word_addr_w;
    logic        cyc_w, stb_w, valid_w;

    int errors = 0;
    int checks = 0;

    cpu_ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .wb_adr_o(wb_adr), .wb_dat_i(wb_dat),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack),
        .flush_i(flush), .flush_addr_i(flush_addr), .valid_o(valid),
        .ready_i(ready), .word_o(word), .word_addr_o(word_addr)
    );

    cpu_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk_i(clk), .rst_i(rst_w), .wb_adr_o(adr_w), .wb_dat_i(dat_w),
        .wb_cyc_o(cyc_w), .wb_stb_o(stb_w), .wb_ack_i(ack_w),
        .flush_i(flush_w), .flush_addr_i(flush_addr_w), .valid_o(valid_w),
        .ready_i(ready_w), .word_o(word_w), .word_addr_o(word_addr_w)
    );

    task automatic do_reset();
        rst = 1'b1; wb_ack = 1'b0; flush = 1'b0; ready = 1'b0;
        wb_dat = '0; flush_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_ack = 1'b0; flush = 1'b0; ready = 1'b0;
        wb_dat = '0; flush_addr = '0;
        repeat (2) @(negedge clk);
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
        checks++; if (wb_adr !== 32'h1000) begin errors++; $display("FAIL reset_adr: got %h want 00001000", wb_adr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", word); end
        checks++; if (word_addr !== 32'h0) begin errors++; $display("FAIL reset_word_addr: got %h want 0", word_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1000) begin
            errors++; $display("FAIL first_req: got stb=%b adr=%h want stb=1 adr=00001000", wb_stb, wb_adr);
        end
        wb_ack = 1'b1; wb_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        wb_ack = 1'b0;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", valid); end
        checks++; if (word !== 32'hDEAD_BEEF) begin errors++; $display("FAIL first_word: got %h want deadbeef", word); end
        checks++; if (word_addr !== 32'h1000) begin errors++; $display("FAIL first_word_addr: got %h want 00001000", word_addr); end
    endtask

    task automatic test_fill();
        logic [31:0] seen[$];
        int          more;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wb_ack = wb_stb; wb_dat = 32'hA000_0000 + i;
            if (wb_stb) seen.push_back(wb_adr);
            @(negedge clk);
        end
        wb_ack = 1'b0;
        checks++; if (seen.size() != DEPTH) begin errors++; $display("FAIL fill_acks: got %0d want %0d", seen.size(), DEPTH); end
        for (int i = 0; i < seen.size() && i < DEPTH; i++) begin
            checks++; if (seen[i] !== 32'h1000 + 32'(4 * i)) begin
                errors++; $display("FAIL fill_adr%0d: got %h want %h", i, seen[i], 32'h1000 + 32'(4 * i));
            end
        end
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL fill_stb_low: got %b want 0", wb_stb); end
        checks++; if (valid !== 1'b1 || word_addr !== 32'h1000) begin
            errors++; $display("FAIL fill_head: got valid=%b addr=%h want 1 00001000", valid, word_addr);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1010) begin
            errors++; $display("FAIL refill_req: got stb=%b adr=%h want 1 00001010", wb_stb, wb_adr);
        end
        checks++; if (word_addr !== 32'h1004) begin errors++; $display("FAIL refill_head: got %h want 00001004", word_addr); end
        more = 0;
        for (int i = 0; i < 6; i++) begin
            wb_ack = wb_stb;
            if (wb_stb) more++;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        checks++; if (more != 1) begin errors++; $display("FAIL refill_count: got %0d want 1", more); end
        checks++; if (wb_stb !== 1'b0) begin errors++; $display("FAIL refill_stb_low: got %b want 0", wb_stb); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        flush = 1'b1; flush_addr = 32'h2003;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h1000 || valid !== 1'b0) begin
                errors++; $display("FAIL flush_wait_hold%0d: got stb=%b adr=%h valid=%b want 1 00001000 0", i, wb_stb, wb_adr, valid);
            end
            wb_ack = (i == 2); wb_dat = 32'h1111_1111;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_wait_drop: got valid=%b want 0", valid); end
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h2000) begin
            errors++; $display("FAIL flush_wait_redirect: got stb=%b adr=%h want 1 00002000", wb_stb, wb_adr);
        end
        wb_ack = 1'b1; wb_dat = 32'h2222_2222;
        @(negedge clk);
        wb_ack = 1'b0;
        checks++; if (valid !== 1'b1 || word_addr !== 32'h2000 || word !== 32'h2222_2222) begin
            errors++; $display("FAIL flush_wait_word: got valid=%b addr=%h word=%h want 1 00002000 22222222", valid, word_addr, word);
        end
    endtask

    task automatic test_flush_ack_pop();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wb_ack = 1'b1; wb_dat = 32'h5000 + i;
            @(negedge clk);
        end
        checks++; if (valid !== 1'b1 || wb_stb !== 1'b1) begin
            errors++; $display("FAIL fap_pre: got valid=%b stb=%b want 1 1", valid, wb_stb);
        end
        flush = 1'b1; flush_addr = 32'h3000; wb_ack = 1'b1; ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fap_valid: got %b want 0", valid); end
        checks++; if (wb_stb !== 1'b1 || wb_adr !== 32'h3000) begin
            errors++; $display("FAIL fap_redirect: got stb=%b adr=%h want 1 00003000", wb_stb, wb_adr);
        end
        wb_ack = 1'b1; wb_dat = 32'hCAFE_F00D;
        @(negedge clk);
        wb_ack = 1'b0;
        checks++; if (valid !== 1'b1 || word_addr !== 32'h3000 || word !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL fap_word: got valid=%b addr=%h word=%h want 1 00003000 cafef00d", valid, word_addr, word);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fap_count: got valid=%b want 0 after single pop", valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [3];
        logic [31:0] dq[$];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
        rst_w = 1'b0;
        @(negedge clk);
        checks++; if (stb_w !== 1'b1 || cyc_w !== 1'b1 || adr_w !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL wrap_first: got stb=%b cyc=%b adr=%h want 1 1 fffffff8", stb_w, cyc_w, adr_w);
        end
        ready_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ack_w = stb_w; dat_w = $urandom; dq.push_back(dat_w);
            @(negedge clk);
            checks++; if (valid_w !== 1'b1 || word_addr_w !== exp_addr[i] || word_w !== dq[i]) begin
                errors++; $display("FAIL wrap_seq%0d: got valid=%b addr=%h word=%h want 1 %h %h", i, valid_w, word_addr_w, word_w, exp_addr[i], dq[i]);
            end
        end
        ack_w = 1'b0; ready_w = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1; wb_dat = 32'h7000 + i;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        checks++; if (valid !== 1'b1 || wb_stb !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got valid=%b stb=%b want 1 1", valid, wb_stb);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL areset_drop: got stb=%b cyc=%b valid=%b want 0 0 0", wb_stb, wb_cyc, valid);
        end
        checks++; if (wb_adr !== 32'h1000) begin errors++; $display("FAIL areset_adr: got %h want 00001000", wb_adr); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [31:0] exp_fa, prev_adr;
        logic        drop, prev_pend;
        do_reset();
        exp_fa = 32'h1000; drop = 1'b0; prev_pend = 1'b0; prev_adr = '0;
        for (int c = 0; c < 600; c++) begin
            checks++; if (valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++; if ({word_addr, word} !== q[0]) begin
                    errors++; $display("FAIL rnd_head c=%0d: got %h want %h", c, {word_addr, word}, q[0]);
                end
            end
            checks++; if (wb_cyc !== wb_stb) begin errors++; $display("FAIL rnd_cyc c=%0d: got %b want %b", c, wb_cyc, wb_stb); end
            if (prev_pend) begin
                checks++; if (wb_stb !== 1'b1 || wb_adr !== prev_adr) begin
                    errors++; $display("FAIL rnd_hold c=%0d: got stb=%b adr=%h want 1 %h", c, wb_stb, wb_adr, prev_adr);
                end
            end
            if (wb_stb !== 1'b1) begin
                checks++; if (q.size() != DEPTH) begin
                    errors++; $display("FAIL rnd_idle c=%0d: got idle with %0d queued want %0d", c, q.size(), DEPTH);
                end
            end
            wb_ack     = wb_stb && ($urandom_range(0, 2) != 0);
            wb_dat     = $urandom;
            ready      = ($urandom_range(0, 3) < ((c < 300) ? 1 : 3));
            flush      = ($urandom_range(0, 11) == 0);
            flush_addr = $urandom;
            if (flush) begin
                q.delete();
                drop   = wb_stb && !wb_ack && (drop || 1'b1);
                exp_fa = {flush_addr[31:2], 2'b00};
            end else begin
                if (valid && ready && q.size() != 0) void'(q.pop_front());
                if (wb_stb && wb_ack) begin
                    if (drop) begin
                        drop = 1'b0;
                    end else begin
                        checks++; if (wb_adr !== exp_fa) begin
                            errors++; $display("FAIL rnd_adr c=%0d: got %h want %h", c, wb_adr, exp_fa);
                        end
                        q.push_back({wb_adr, wb_dat});
                        exp_fa = exp_fa + 32'd4;
                        checks++; if (q.size() > DEPTH) begin
                            errors++; $display("FAIL rnd_overflow c=%0d: got %0d entries want <= %0d", c, q.size(), DEPTH);
                        end
                    end
                end
            end
            prev_pend = wb_stb && !wb_ack;
            prev_adr  = wb_adr;
            @(negedge clk);
        end
        wb_ack = 1'b0; flush = 1'b0; ready = 1'b0;
    endtask

    initial begin
        rst_w = 1'b1; ack_w = 1'b0; flush_w = 1'b0; ready_w = 1'b0;
        dat_w = '0; flush_addr_w = '0;
        test_reset();
        test_fill();
        test_flush_wait();
        test_flush_ack_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
